// File: rtl/s_mem_pkg.sv
// Shared definitions for the five-bank S operand memory and its DMA writer.
package s_mem_pkg;

    localparam int NUM_S_BANKS = 5;
    localparam int S_BANK_AW   = 9;
    localparam int S_BANK_DW   = 32;
    localparam int S_CAPACITY  = 2560;

    typedef logic [S_BANK_AW-1:0] s_bank_addr_t;
    typedef logic [2:0]           s_bank_idx_t;

    typedef enum logic [1:0] {IDLE, RUN, FIN} s_dma_state_e;

    // Bank index plus a small step, wrapped modulo the bank count.
    function automatic s_bank_idx_t bank_add(input s_bank_idx_t b, input logic [1:0] step);
        logic [3:0] sum;
        sum = {1'b0, b} + {2'b00, step};
        if (sum >= 4'(NUM_S_BANKS))
            sum = sum - 4'(NUM_S_BANKS);
        return sum[2:0];
    endfunction

endpackage

// File: rtl/s_bank_ptr.sv
// Interleave pointer: bank index b (mod 5) and absolute row (base + r, mod 512).
// Presents the bank/address pair for the low and high word lanes of a beat.
module s_bank_ptr
    import s_mem_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         advance,
    input  s_bank_addr_t base_addr,
    output s_bank_idx_t  lo_bank,
    output s_bank_addr_t lo_addr,
    output s_bank_idx_t  hi_bank,
    output s_bank_addr_t hi_addr
);

    s_bank_idx_t  b_q;
    s_bank_addr_t row_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q   <= '0;
            row_q <= '0;
        end else if (load) begin
            b_q   <= '0;
            row_q <= base_addr;
        end else if (advance) begin
            b_q <= bank_add(b_q, 2'd2);
            // Banks 3 and 4 start a pair that crosses into the next row.
            if (b_q >= 3'd3)
                row_q <= row_q + s_bank_addr_t'(1);
        end
    end

    assign lo_bank = b_q;
    assign lo_addr = row_q;
    assign hi_bank = bank_add(b_q, 2'd1);
    assign hi_addr = (b_q == 3'd4) ? row_q + s_bank_addr_t'(1) : row_q;

endmodule

// File: rtl/s_bank_dma_writer.sv
// DMA-side writer: splits 64-bit stream beats into 32-bit words and writes them
// interleaved across the S banks (word i -> bank i mod 5, row base + i/5).
module s_bank_dma_writer
    import s_mem_pkg::*;
#(
    parameter int NUM_BANKS = NUM_S_BANKS,
    parameter int BANK_AW   = S_BANK_AW,
    parameter int BANK_DW   = S_BANK_DW,
    parameter int IN_DW     = 2 * BANK_DW,
    parameter int CNT_W     = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [BANK_AW-1:0]             base_addr,
    input  logic [CNT_W-1:0]               word_count,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [IN_DW-1:0]               s_data,
    output logic [NUM_BANKS-1:0]           bank_en,
    output logic [NUM_BANKS-1:0]           bank_we,
    output logic [NUM_BANKS*BANK_AW-1:0]   bank_addr,
    output logic [NUM_BANKS*BANK_DW-1:0]   bank_din
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(S_CAPACITY);

    s_dma_state_e state_q, state_d;
    logic [CNT_W-1:0] rem_q;
    logic             hs, load, too_big, err_q;

    s_bank_idx_t  lo_bank, hi_bank;
    s_bank_addr_t lo_addr, hi_addr;

    logic [NUM_BANKS-1:0]         we_q, we_d;
    logic [NUM_BANKS*BANK_AW-1:0] addr_q, addr_d;
    logic [NUM_BANKS*BANK_DW-1:0] din_q, din_d;

    assign hs      = s_valid && s_ready;
    assign too_big = word_count > CAP;
    assign load    = (state_q == IDLE) && start && (word_count != '0) && !too_big;

    s_bank_ptr u_ptr (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (hs),
        .base_addr (base_addr),
        .lo_bank   (lo_bank),
        .lo_addr   (lo_addr),
        .hi_bank   (hi_bank),
        .hi_addr   (hi_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count == '0)
                        state_d = FIN;
                    else if (!too_big)
                        state_d = RUN;
                end
            end
            RUN:     if (hs && rem_q <= CNT_W'(2)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        s_ready = 1'b0;
        done    = 1'b0;
        case (state_q)
            RUN: begin
                busy    = 1'b1;
                s_ready = 1'b1;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == IDLE) && start && too_big;
            if (load)
                rem_q <= word_count;
            else if (hs)
                rem_q <= (rem_q >= CNT_W'(2)) ? rem_q - CNT_W'(2) : '0;
        end
    end

    // The two lanes of a beat always land in different banks, so each bank
    // sees at most one write per cycle.
    always_comb begin
        we_d   = '0;
        addr_d = '0;
        din_d  = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (hs && lo_bank == s_bank_idx_t'(k)) begin
                we_d[k]                        = 1'b1;
                addr_d[k*BANK_AW +: BANK_AW]   = lo_addr;
                din_d[k*BANK_DW +: BANK_DW]    = s_data[BANK_DW-1:0];
            end else if (hs && rem_q >= CNT_W'(2) && hi_bank == s_bank_idx_t'(k)) begin
                we_d[k]                        = 1'b1;
                addr_d[k*BANK_AW +: BANK_AW]   = hi_addr;
                din_d[k*BANK_DW +: BANK_DW]    = s_data[IN_DW-1:BANK_DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= '0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            din_q  <= din_d;
        end
    end

    assign err       = err_q;
    assign bank_en   = we_q;
    assign bank_we   = we_q;
    assign bank_addr = addr_q;
    assign bank_din  = din_q;

endmodule

// File: tb/tb_s_bank_dma_writer.sv
// Scoreboard bench for s_bank_dma_writer: expected bank writes are queued in word
// order when a transfer is issued; a negedge monitor pops and compares them.
module tb_s_bank_dma_writer;

    localparam int NB = 5;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int IW = 64;
    localparam int CW = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [CW-1:0]    word_count;
    logic             busy, done, err;
    logic             s_valid, s_ready;
    logic [IW-1:0]    s_data;
    logic [NB-1:0]    bank_en, bank_we;
    logic [NB*AW-1:0] bank_addr;
    logic [NB*DW-1:0] bank_din;

    always #5 clk = ~clk;

    s_bank_dma_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .bank_en    (bank_en),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_din   (bank_din)
    );

    typedef struct {
        int          bank;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  tb_rem = 0;
    bit  exp_done = 0;
    bit  hs_prev = 0;
    int  done_cnt = 0;
    int  written[NB][512];

    function automatic void check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: compares every cycle away from the active edge.
    always @(negedge clk) begin
        int  nw;
        bit  hs;
        wr_t e;
        if (rst) begin
            hs_prev  = 0;
            exp_done = 0;
        end else begin
            check("write_only_after_handshake", |bank_we, hs_prev);
            check("en_equals_we", bank_en, bank_we);
            check("done", done, exp_done);
            nw = $countones(bank_we);
            for (int k = 0; k < nw; k++) begin
                check("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write_bank", bank_we[e.bank], 1);
                    check("write_addr", bank_addr[e.bank*AW +: AW], e.addr);
                    check("write_data", bank_din[e.bank*DW +: DW], e.data);
                end
            end
            for (int k = 0; k < NB; k++)
                if (bank_we[k]) written[k][bank_addr[k*AW +: AW]]++;
            if (done) done_cnt++;
            hs       = s_valid && s_ready;
            exp_done = 0;
            if (hs) begin
                if (tb_rem <= 2) begin
                    tb_rem   = 0;
                    exp_done = 1;
                end else begin
                    tb_rem -= 2;
                end
            end
            hs_prev = hs;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int c);
        base_addr  = AW'(b);
        word_count = CW'(c);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // mode 0: back-to-back, 1: one idle cycle after each beat, 2: random gaps
    task automatic send_beat(input logic [63:0] d, input int mode);
        int guard;
        bit hs;
        if (mode == 2)
            while ($urandom_range(0, 2) == 0) tick();
        s_valid = 1'b1;
        s_data  = d;
        guard   = 0;
        do begin
            @(negedge clk);
            hs = s_ready;
            tick();
            guard++;
        end while (!hs && guard < 200);
        s_valid = 1'b0;
        if (!hs) check("ready_timeout", hs, 1);
        if (mode == 1) tick();
    endtask

    task automatic run_xfer(input int base, input int count, input int mode, input bit pattern,
                            input int restart_at, input int abort_after);
        logic [31:0] w[$];
        logic [31:0] hi;
        int          dc0;
        int          guard;
        int          nb;
        for (int i = 0; i < count; i++)
            w.push_back(pattern ? 32'(32'h100 + i) : $urandom);
        for (int i = 0; i < count; i++)
            exp_q.push_back('{i % NB, (base + i / NB) % 512, w[i]});
        tb_rem = count;
        dc0    = done_cnt;
        do_start(base, count);
        check("busy_in_run", busy, 1);
        nb = (count + 1) / 2;
        for (int j = 0; j < nb; j++) begin
            if (j == abort_after) begin
                tick();
                #2 rst = 1'b1;
                #1;
                check("reset_ctrl_zero", {busy, done, err, s_ready}, 0);
                check("reset_bank_zero", {|bank_en, |bank_we, |bank_addr, |bank_din}, 0);
                exp_q.delete();
                tb_rem = 0;
                tick();
                #3 rst = 1'b0;
                repeat (4) tick();
                check("no_done_after_abort", done_cnt - dc0, 0);
                check("idle_after_abort", busy, 0);
                return;
            end
            if (j == restart_at) begin
                base_addr  = AW'($urandom);
                word_count = CW'($urandom_range(1, 40));
                start      = 1'b1;
                tick();
                start      = 1'b0;
            end
            hi = (2 * j + 1 < count) ? w[2*j+1] : $urandom;
            send_beat({hi, w[2*j]}, mode);
        end
        guard = 0;
        while (done_cnt == dc0 && guard < 20) begin
            tick();
            guard++;
        end
        check("done_count", done_cnt - dc0, 1);
        tick();
        check("busy_after_done", busy, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int dc0;
        int bad;
        rst        = 1'b1;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        base_addr  = '0;
        word_count = '0;
        #12;
        check("por_ctrl_zero", {busy, done, err, s_ready}, 0);
        check("por_bank_zero", {|bank_en, |bank_we, |bank_addr, |bank_din}, 0);
        #3 rst = 1'b0;
        tick();

        // reset mid-RUN after 3 beats, then a normal transfer
        run_xfer(5, 20, 2, 0, -1, 3);
        run_xfer(0, 10, 0, 1, -1, -1);

        // row wrap with toggling valid; last beat writes only bank 1
        run_xfer(9'h1FF, 7, 1, 0, -1, -1);

        // zero-length transfer
        dc0 = done_cnt;
        do_start(3, 0);
        exp_done = 1;
        check("zero_len_busy", busy, 1);
        check("zero_len_ready", s_ready, 0);
        repeat (3) tick();
        check("zero_len_done", done_cnt - dc0, 1);

        // oversize rejects
        dc0 = done_cnt;
        do_start(0, 2561);
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        tick();
        check("err_one_cycle", err, 0);
        do_start(7, 4095);
        check("err_pulse_max", err, 1);
        repeat (3) tick();
        check("err_no_done", done_cnt - dc0, 0);
        check("err_idle", busy, 0);

        // start during RUN is ignored
        run_xfer(9'h20, 12, 0, 0, 2, -1);

        // randomized transfers
        for (int t = 0; t < 8; t++)
            run_xfer($urandom_range(0, 511), $urandom_range(1, 60), 2, 0, -1, -1);

        // full capacity: every bank row written exactly once
        for (int k = 0; k < NB; k++)
            for (int a = 0; a < 512; a++) written[k][a] = 0;
        run_xfer(0, 2560, 0, 0, -1, -1);
        for (int k = 0; k < NB; k++) begin
            bad = 0;
            for (int a = 0; a < 512; a++)
                if (written[k][a] != 1) bad++;
            check($sformatf("full_cover_bank%0d", k), bad, 0);
        end

        // wrapped full-capacity transfer is not an error
        run_xfer(9'h055, 2560, 0, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
